conv_ofm_collector: RTL and testbench

//  Receive end of the Convolution output interface (out_valid / Out_OFM).

---
 rtl/conv_ofm_collector_if.sv | 27 ++
 rtl/conv_ofm_collector.sv | 158 +++++++++++++++
 tb/tb_conv_ofm_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/conv_ofm_collector_if.sv
// Bundle of the convolution-output capture port and the buffered read port
// of conv_ofm_collector.
interface conv_ofm_collector_if #(
  parameter int OFM_W = 13,
  parameter int SUM_W = 17
);
  logic             out_valid;
  logic [OFM_W-1:0] Out_OFM;
  logic             rd_ready;
  logic             rd_valid;
  logic [OFM_W-1:0] rd_data;
  logic             rd_last;
  logic             frame_done;
  logic [OFM_W-1:0] ofm_max;
  logic [SUM_W-1:0] ofm_sum;
  logic             overflow_err;

  modport slave (
    input  out_valid, Out_OFM, rd_ready,
    output rd_valid, rd_data, rd_last, frame_done, ofm_max, ofm_sum, overflow_err
  );

  modport master (
    output out_valid, Out_OFM, rd_ready,
    input  rd_valid, rd_data, rd_last, frame_done, ofm_max, ofm_sum, overflow_err
  );
endinterface

// File: rtl/conv_ofm_collector.sv
// Captures one OFM frame from the convolution block, tracks its max and sum,
// then drains the buffered words over a valid/ready read port.
module conv_ofm_collector #(
  parameter int OFM_W     = 13,
  parameter int OFM_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int SUM_W     = 17
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_ofm_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OFM_DEPTH - 1);

  logic [OFM_W-1:0]  mem_r [OFM_DEPTH];
  state_t            state_r, state_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [ADDR_W-1:0] rd_ptr_inc_s;
  logic              rd_valid_r, rd_valid_s;
  logic [OFM_W-1:0]  rd_data_r, rd_data_s;
  logic              rd_last_r, rd_last_s;
  logic              frame_done_r, frame_done_s;
  logic [OFM_W-1:0]  max_r, max_s;
  logic [SUM_W-1:0]  sum_r, sum_s;
  logic              ovf_r, ovf_s;
  logic              we_s;
  logic [ADDR_W-1:0] wa_s;

  assign rd_ptr_inc_s = rd_ptr_r + ADDR_W'(1);

  // Next-state, buffer write strobe and next values of every registered output
  always_comb begin
    state_s      = state_r;
    wr_ptr_s     = wr_ptr_r;
    rd_ptr_s     = rd_ptr_r;
    rd_valid_s   = rd_valid_r;
    rd_data_s    = rd_data_r;
    rd_last_s    = rd_last_r;
    frame_done_s = 1'b0;
    max_s        = max_r;
    sum_s        = sum_r;
    ovf_s        = ovf_r;
    we_s         = 1'b0;
    wa_s         = wr_ptr_r;
    case (state_r)
      IDLE: begin
        if (bus.out_valid) begin
          // First word of a frame restarts the statistics.
          we_s     = 1'b1;
          wa_s     = {ADDR_W{1'b0}};
          max_s    = bus.Out_OFM;
          sum_s    = SUM_W'(bus.Out_OFM);
          wr_ptr_s = ADDR_W'(1);
          state_s  = COLLECT;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (bus.out_valid) begin
          we_s  = 1'b1;
          wa_s  = wr_ptr_r;
          max_s = (bus.Out_OFM > max_r) ? bus.Out_OFM : max_r;
          sum_s = sum_r + SUM_W'(bus.Out_OFM);
          if (wr_ptr_r == LAST_ADDR) begin
            // buf[0] is already written, so the first read word can be preloaded.
            wr_ptr_s     = {ADDR_W{1'b0}};
            rd_ptr_s     = {ADDR_W{1'b0}};
            rd_valid_s   = 1'b1;
            rd_data_s    = mem_r[0];
            rd_last_s    = 1'b0;
            frame_done_s = 1'b1;
            state_s      = DRAIN;
          end else begin
            wr_ptr_s = wr_ptr_r + ADDR_W'(1);
          end
        end else begin
          state_s = COLLECT;
        end
      end
      DRAIN: begin
        if (bus.out_valid) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        if (rd_valid_r && bus.rd_ready) begin
          if (rd_last_r) begin
            rd_valid_s = 1'b0;
            rd_last_s  = 1'b0;
            rd_ptr_s   = {ADDR_W{1'b0}};
            state_s    = IDLE;
          end else begin
            rd_ptr_s  = rd_ptr_inc_s;
            rd_data_s = mem_r[rd_ptr_inc_s];
            rd_last_s = (rd_ptr_inc_s == LAST_ADDR);
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {ADDR_W{1'b0}};
      rd_ptr_r     <= {ADDR_W{1'b0}};
      rd_valid_r   <= 1'b0;
      rd_data_r    <= {OFM_W{1'b0}};
      rd_last_r    <= 1'b0;
      frame_done_r <= 1'b0;
      max_r        <= {OFM_W{1'b0}};
      sum_r        <= {SUM_W{1'b0}};
      ovf_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      rd_valid_r   <= rd_valid_s;
      rd_data_r    <= rd_data_s;
      rd_last_r    <= rd_last_s;
      frame_done_r <= frame_done_s;
      max_r        <= max_s;
      sum_r        <= sum_s;
      ovf_r        <= ovf_s;
    end
  end

  // Frame buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= bus.Out_OFM;
    end
  end

  assign bus.rd_valid     = rd_valid_r;
  assign bus.rd_data      = rd_data_r;
  assign bus.rd_last      = rd_last_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.ofm_max      = max_r;
  assign bus.ofm_sum      = sum_r;
  assign bus.overflow_err = ovf_r;

endmodule

// File: tb/tb_conv_ofm_collector.sv
// Directed, table-driven bench for conv_ofm_collector: frame capture, statistics,
// drain handshake, overflow flagging and mid-frame reset.
module tb_conv_ofm_collector;

  logic clk;
  logic rst_n;

  conv_ofm_collector_if #(.OFM_W(13), .SUM_W(17)) bus ();

  conv_ofm_collector #(
    .OFM_W(13), .OFM_DEPTH(16), .ADDR_W(4), .SUM_W(17)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [15:0][12:0] words;
    bit                gaps;
    bit                rdy_toggle;
    int                ovf_at;
    logic [12:0]       exp_max;
    logic [16:0]       exp_sum;
  } vec_t;

  vec_t vecs[6];
  vec_t v2;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    int k;
    int c;
    int ng;
    bit rdy;
    // capture phase
    for (int i = 0; i < 16; i++) begin
      ng = v.gaps ? ((i % 3 == 1) ? 1 : ((i % 5 == 2) ? 2 : 0)) : 0;
      for (int g = 0; g < ng; g++) begin
        @(negedge clk);
        bus.out_valid = 1'b0;
        bus.Out_OFM   = 13'd4444;
      end
      @(negedge clk);
      if (i == 15) begin
        chk({v.name, ":done_early"}, 32'(bus.frame_done), 32'd0);
        chk({v.name, ":rdv_early"}, 32'(bus.rd_valid), 32'd0);
      end
      bus.out_valid = 1'b1;
      bus.Out_OFM   = v.words[i];
    end
    @(negedge clk);
    chk({v.name, ":frame_done"}, 32'(bus.frame_done), 32'd1);
    chk({v.name, ":max"}, 32'(bus.ofm_max), 32'(v.exp_max));
    chk({v.name, ":sum"}, 32'(bus.ofm_sum), 32'(v.exp_sum));
    // drain phase
    k = 0;
    c = 0;
    while (k < 16 && c < 100) begin
      if (c > 0) @(negedge clk);
      chk({v.name, ":rd_valid"}, 32'(bus.rd_valid), 32'd1);
      chk({v.name, ":rd_data"}, 32'(bus.rd_data), 32'(v.words[k]));
      chk({v.name, ":rd_last"}, 32'(bus.rd_last), (k == 15) ? 32'd1 : 32'd0);
      if (c == 1) chk({v.name, ":done_pulse"}, 32'(bus.frame_done), 32'd0);
      rdy = v.rdy_toggle ? (c % 3 == 0) : 1'b1;
      bus.rd_ready = rdy;
      if (c == v.ovf_at) begin
        bus.out_valid = 1'b1;
        bus.Out_OFM   = 13'd77;
        exp_ovf       = 1'b1;
      end else begin
        bus.out_valid = 1'b0;
        bus.Out_OFM   = 13'd0;
      end
      if (rdy) k++;
      c++;
    end
    if (k < 16) chk({v.name, ":drain_timeout"}, 32'(k), 32'd16);
    if (!v.rdy_toggle) chk({v.name, ":drain_cycles"}, 32'(c), 32'd16);
    @(negedge clk);
    bus.rd_ready  = 1'b0;
    bus.out_valid = 1'b0;
    chk({v.name, ":idle_rdv"}, 32'(bus.rd_valid), 32'd0);
    chk({v.name, ":idle_last"}, 32'(bus.rd_last), 32'd0);
    chk({v.name, ":idle_done"}, 32'(bus.frame_done), 32'd0);
    chk({v.name, ":hold_max"}, 32'(bus.ofm_max), 32'(v.exp_max));
    chk({v.name, ":hold_sum"}, 32'(bus.ofm_sum), 32'(v.exp_sum));
    chk({v.name, ":ovf"}, 32'(bus.overflow_err), 32'(exp_ovf));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ":rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({nm, ":rd_data"}, 32'(bus.rd_data), 32'd0);
    chk({nm, ":rd_last"}, 32'(bus.rd_last), 32'd0);
    chk({nm, ":frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({nm, ":max"}, 32'(bus.ofm_max), 32'd0);
    chk({nm, ":sum"}, 32'(bus.ofm_sum), 32'd0);
    chk({nm, ":ovf"}, 32'(bus.overflow_err), 32'd0);
  endtask

  initial begin
    // vector table
    for (int i = 0; i < 16; i++) begin
      vecs[0].words[i] = 13'(i + 1);
      vecs[1].words[i] = (i == 0) ? 13'd8191 : ((i == 1) ? 13'd0 : 13'd5);
      vecs[2].words[i] = 13'd7;
      vecs[3].words[i] = 13'(20 + i);
      vecs[4].words[i] = 13'd3;
      vecs[5].words[i] = 13'd4;
      v2.words[i]      = 13'd2;
    end
    vecs[0].name = "ramp";   vecs[0].gaps = 1'b0; vecs[0].rdy_toggle = 1'b0; vecs[0].ovf_at = -1;
    vecs[0].exp_max = 13'd16;   vecs[0].exp_sum = 17'd136;
    vecs[1].name = "gaps";   vecs[1].gaps = 1'b1; vecs[1].rdy_toggle = 1'b0; vecs[1].ovf_at = -1;
    vecs[1].exp_max = 13'd8191; vecs[1].exp_sum = 17'd8261;
    vecs[2].name = "toggle"; vecs[2].gaps = 1'b0; vecs[2].rdy_toggle = 1'b1; vecs[2].ovf_at = -1;
    vecs[2].exp_max = 13'd7;    vecs[2].exp_sum = 17'd112;
    vecs[3].name = "ovf_mid"; vecs[3].gaps = 1'b0; vecs[3].rdy_toggle = 1'b0; vecs[3].ovf_at = 3;
    vecs[3].exp_max = 13'd35;   vecs[3].exp_sum = 17'd440;
    vecs[4].name = "threes"; vecs[4].gaps = 1'b0; vecs[4].rdy_toggle = 1'b0; vecs[4].ovf_at = 15;
    vecs[4].exp_max = 13'd3;    vecs[4].exp_sum = 17'd48;
    vecs[5].name = "fours";  vecs[5].gaps = 1'b0; vecs[5].rdy_toggle = 1'b0; vecs[5].ovf_at = -1;
    vecs[5].exp_max = 13'd4;    vecs[5].exp_sum = 17'd64;
    v2.name = "twos"; v2.gaps = 1'b0; v2.rdy_toggle = 1'b0; v2.ovf_at = -1;
    v2.exp_max = 13'd2; v2.exp_sum = 17'd32;

    rst_n         = 1'b0;
    bus.out_valid = 1'b0;
    bus.Out_OFM   = 13'd0;
    bus.rd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) apply(vecs[t]);

    // reset in the middle of a frame
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.out_valid = 1'b1;
      bus.Out_OFM   = 13'd50;
    end
    @(negedge clk);
    bus.out_valid = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ovf = 1'b0;
    apply(v2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
